tlx_rsp_decode: RTL

- Front end of the AFU response path. Accepts every TLX→AFU response and classifies it.
- Retry-related responses (xlate_pending, xlate_done, rty_req) go out as a one-cycle-registered strobe stream that feeds the retry queue directly.
- Good completions and fatal failures go out on a separate completion stream.
- Also returns TLX response credits, checks for credit overrun, and latches the first fatal response for debug.

---
 rtl/tlx_rsp_pkg.sv | 28 ++
 rtl/tlx_rsp_decode_if.sv | 45 ++++
 rtl/rsp_stat_cnt.sv | 21 ++
 rtl/tlx_rsp_decode.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/tlx_rsp_pkg.sv
// Shared TLX response opcodes, resp_codes and rsp_typ bit positions.
// The retry queue imports the same rsp_typ indices.
package tlx_rsp_pkg;

  localparam logic [7:0] OP_READ_RESP    = 8'h04;
  localparam logic [7:0] OP_READ_FAILED  = 8'h05;
  localparam logic [7:0] OP_WRITE_RESP   = 8'h08;
  localparam logic [7:0] OP_WRITE_FAILED = 8'h09;
  localparam logic [7:0] OP_INTRP_RESP   = 8'h0C;
  localparam logic [7:0] OP_XLATE_DONE   = 8'h18;

  localparam logic [3:0] RC_DONE          = 4'h0;
  localparam logic [3:0] RC_RTY_REQ       = 4'h2;
  localparam logic [3:0] RC_XLATE_PENDING = 4'h4;

  localparam int TYP_W             = 5;
  localparam int TYP_XPEND         = 0;
  localparam int TYP_XDONE_BACKOFF = 1;
  localparam int TYP_XDONE_IMM     = 2;
  localparam int TYP_RTY_REQ       = 3;
  localparam int TYP_PARTIAL       = 4;

  typedef enum logic {
    ERR_IDLE = 1'b0,
    ERR_HELD = 1'b1
  } err_state_e;

endpackage

// File: rtl/tlx_rsp_decode_if.sv
// TLX response bus, credit return, retry strobe stream and completion stream.
// master = TLX/test side, slave = decoder.
interface tlx_rsp_decode_if #(
  parameter int TAGW = 7
);
  import tlx_rsp_pkg::*;

  logic             tlx_afu_resp_valid;
  logic [7:0]       tlx_afu_resp_opcode;
  logic [15:0]      tlx_afu_resp_afutag;
  logic [3:0]       tlx_afu_resp_code;
  logic [1:0]       tlx_afu_resp_dp;
  logic [1:0]       tlx_afu_resp_dl;

  logic [6:0]       afu_tlx_resp_initial_credit;
  logic             afu_tlx_resp_credit;

  logic             rsp_den;
  logic [1:0]       rsp_pos;
  logic [TAGW-1:0]  rsp_tag;
  logic [TYP_W-1:0] rsp_typ;

  logic             cmpl_valid;
  logic             cmpl_ok;
  logic [TAGW-1:0]  cmpl_tag;
  logic [1:0]       cmpl_pos;
  logic [1:0]       cmpl_dl;

  modport master (
    output tlx_afu_resp_valid, tlx_afu_resp_opcode, tlx_afu_resp_afutag,
           tlx_afu_resp_code, tlx_afu_resp_dp, tlx_afu_resp_dl,
    input  afu_tlx_resp_initial_credit, afu_tlx_resp_credit,
           rsp_den, rsp_pos, rsp_tag, rsp_typ,
           cmpl_valid, cmpl_ok, cmpl_tag, cmpl_pos, cmpl_dl
  );

  modport slave (
    input  tlx_afu_resp_valid, tlx_afu_resp_opcode, tlx_afu_resp_afutag,
           tlx_afu_resp_code, tlx_afu_resp_dp, tlx_afu_resp_dl,
    output afu_tlx_resp_initial_credit, afu_tlx_resp_credit,
           rsp_den, rsp_pos, rsp_tag, rsp_typ,
           cmpl_valid, cmpl_ok, cmpl_tag, cmpl_pos, cmpl_dl
  );

endinterface

// File: rtl/rsp_stat_cnt.sv
// Saturating 32-bit event counter; clr has priority over inc.
// Count is visible the cycle after the inc pulse.
module rsp_stat_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        clr,
  output logic [31:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/tlx_rsp_decode.sv
// Classifies TLX responses into retry strobes / completions, 1-cycle latency, no backpressure.
// Returns credits, flags credit overrun, captures first fatal; RSP_STATS_EN adds event counters.
module tlx_rsp_decode
  import tlx_rsp_pkg::*;
#(
  parameter int TAGW        = 7,
  parameter int PRT_BIT     = 15,
  parameter int INIT_CREDIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  tlx_rsp_decode_if.slave   bus,
  input  logic              err_clear,
  output logic              err_valid,
  output logic [29:0]       err_info,
  output logic              credit_overrun
`ifdef RSP_STATS_EN
  ,
  output logic [31:0]       stat_retry,
  output logic [31:0]       stat_xpend,
  output logic [31:0]       stat_fail
`endif
);

  logic             resp_vld;
  logic [7:0]       op;
  logic [3:0]       code;
  logic [15:0]      afutag;

  logic [TYP_W-1:0] typ_d;
  logic             den_d;
  logic             cmpl_d;
  logic             ok_d;
  logic             fatal_d;

  assign resp_vld = bus.tlx_afu_resp_valid;
  assign op       = bus.tlx_afu_resp_opcode;
  assign code     = bus.tlx_afu_resp_code;
  assign afutag   = bus.tlx_afu_resp_afutag;

  assign bus.afu_tlx_resp_initial_credit = 7'(INIT_CREDIT);

  // A fatal XLATE_DONE still emits xdone_backoff so pending/done stay paired downstream.
  always_comb begin
    typ_d   = '0;
    cmpl_d  = 1'b0;
    ok_d    = 1'b0;
    fatal_d = 1'b0;
    if (resp_vld) begin
      case (op)
        OP_READ_FAILED, OP_WRITE_FAILED: begin
          if (code == RC_XLATE_PENDING)  typ_d[TYP_XPEND]   = 1'b1;
          else if (code == RC_RTY_REQ)   typ_d[TYP_RTY_REQ] = 1'b1;
          else begin
            cmpl_d  = 1'b1;
            fatal_d = 1'b1;
          end
        end
        OP_XLATE_DONE: begin
          if (code == RC_DONE) begin
            typ_d[TYP_XDONE_IMM] = 1'b1;
          end else begin
            typ_d[TYP_XDONE_BACKOFF] = 1'b1;
            fatal_d = (code != RC_RTY_REQ);
          end
        end
        OP_READ_RESP, OP_WRITE_RESP, OP_INTRP_RESP: begin
          cmpl_d = 1'b1;
          ok_d   = 1'b1;
        end
        default: fatal_d = 1'b1;
      endcase
      typ_d[TYP_PARTIAL] = (|typ_d[TYP_RTY_REQ:TYP_XPEND]) & afutag[PRT_BIT];
    end
  end

  assign den_d = |typ_d[TYP_RTY_REQ:TYP_XPEND];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_den             <= 1'b0;
      bus.rsp_typ             <= '0;
      bus.rsp_tag             <= '0;
      bus.rsp_pos             <= '0;
      bus.cmpl_valid          <= 1'b0;
      bus.cmpl_ok             <= 1'b0;
      bus.cmpl_tag            <= '0;
      bus.cmpl_pos            <= '0;
      bus.cmpl_dl             <= '0;
      bus.afu_tlx_resp_credit <= 1'b0;
    end else begin
      bus.rsp_den             <= den_d;
      bus.rsp_typ             <= typ_d;
      bus.rsp_tag             <= den_d ? afutag[TAGW-1:0] : '0;
      bus.rsp_pos             <= den_d ? bus.tlx_afu_resp_dp : '0;
      bus.cmpl_valid          <= cmpl_d;
      bus.cmpl_ok             <= ok_d;
      bus.cmpl_tag            <= cmpl_d ? afutag[TAGW-1:0] : '0;
      bus.cmpl_pos            <= cmpl_d ? bus.tlx_afu_resp_dp : '0;
      bus.cmpl_dl             <= cmpl_d ? bus.tlx_afu_resp_dl : '0;
      bus.afu_tlx_resp_credit <= resp_vld;
    end
  end

  // TLX's view of its credits: a returned credit counts once TLX has sampled the pulse.
  logic [6:0] tlx_credits;
  logic       credit_seen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tlx_credits   <= 7'(INIT_CREDIT);
      credit_seen_q <= 1'b0;
    end else begin
      credit_seen_q <= bus.afu_tlx_resp_credit;
      case ({resp_vld, credit_seen_q})
        2'b10: if (tlx_credits != 7'd0)     tlx_credits <= tlx_credits - 7'd1;
        2'b01: if (tlx_credits != 7'h7f)    tlx_credits <= tlx_credits + 7'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                credit_overrun <= 1'b0;
    else if (err_clear)                        credit_overrun <= 1'b0;
    else if (resp_vld && tlx_credits == 7'd0)  credit_overrun <= 1'b1;
  end

  err_state_e err_state;
  err_state_e err_state_nxt;
  logic       err_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_state <= ERR_IDLE;
    else        err_state <= err_state_nxt;
  end

  always_comb begin
    err_state_nxt = err_state;
    err_load      = 1'b0;
    if (err_clear) begin
      err_state_nxt = ERR_IDLE;
    end else if (err_state == ERR_IDLE && fatal_d) begin
      err_state_nxt = ERR_HELD;
      err_load      = 1'b1;
    end
  end

  assign err_valid = (err_state == ERR_HELD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        err_info <= '0;
    else if (err_clear) err_info <= '0;
    else if (err_load)  err_info <= {op, code, afutag, bus.tlx_afu_resp_dp};
  end

`ifdef RSP_STATS_EN
  logic fail_d;
  // Unknown opcodes produce neither a retry strobe nor a completion.
  assign fail_d = (cmpl_d & ~ok_d) | (resp_vld & ~den_d & ~cmpl_d);

  rsp_stat_cnt u_stat_retry (
    .clk (clk), .rst_n (rst_n), .inc (typ_d[TYP_RTY_REQ]), .clr (err_clear), .cnt (stat_retry)
  );
  rsp_stat_cnt u_stat_xpend (
    .clk (clk), .rst_n (rst_n), .inc (typ_d[TYP_XPEND]), .clr (err_clear), .cnt (stat_xpend)
  );
  rsp_stat_cnt u_stat_fail (
    .clk (clk), .rst_n (rst_n), .inc (fail_d), .clr (err_clear), .cnt (stat_fail)
  );
`endif

endmodule
